counter_rr_scheduler: RTL and testbench

- Shares one external loadable up-counter (sync load, +1 per clock otherwise) among NUM_REQ requesters.
- Round-robin arbitration; for the winner it loads a start value, lets the counter run for a requested number of cycles, then captures the final count and signals completion.
- Sits between requester logic and the counter instance; it is the only driver of the counter's load controls.

---
 rtl/ctr_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/counter_rr_scheduler.sv | 123 ++++++++++++
 tb/tb_counter_rr_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_sched_pkg.sv
// Shared definitions for the counter round-robin scheduler: FSM encoding and
// default geometry.
package ctr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LEN_W   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward from
// the requester after last_grant, with wrap. The pointer itself lives in the caller.
module rr_arbiter
  import ctr_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic [NUM_REQ-1:0]         onehot
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] cand;

  // Walk from farthest to nearest so the nearest asserted request is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDW'((int'(last_grant) + i) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    onehot = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/counter_rr_scheduler.sv
// Shares one loadable up-counter among NUM_REQ requesters with round-robin
// arbitration. Define CTR_SCHED_ABORT_EN to end an op early when its request drops.
module counter_rr_scheduler
  import ctr_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_ldvalue,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [WIDTH-1:0]           result,
  output logic                       aborted,
  output logic                       ctr_ld,
  output logic [WIDTH-1:0]           ctr_ldvalue,
  input  logic [WIDTH-1:0]           ctr_dout
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t             state;
  logic [IDW-1:0]     id;
  logic [IDW-1:0]     last_grant;
  logic [LEN_W-1:0]   remaining;
  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               abort_now;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx),
    .onehot     (pick_onehot)
  );

  assign busy = (state != ST_IDLE);

`ifdef CTR_SCHED_ABORT_EN
  logic abort_seen;

  assign abort_now = (state == ST_COUNT) && !req[id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_seen <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        abort_seen <= 1'b0;
      end else if (abort_now) begin
        abort_seen <= 1'b1;
      end
      if (state == ST_DONE) begin
        aborted <= abort_seen;
      end
    end
  end
`else
  assign abort_now = 1'b0;
  assign aborted   = 1'b0;
`endif

  // ctr_ldvalue doubles as the latched start value for the whole op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      id          <= '0;
      last_grant  <= IDW'(NUM_REQ - 1);
      remaining   <= '0;
      gnt         <= '0;
      ctr_ld      <= 1'b0;
      ctr_ldvalue <= '0;
      done        <= 1'b0;
      done_id     <= '0;
      result      <= '0;
    end else begin
      done   <= 1'b0;
      ctr_ld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            id          <= pick_idx;
            ctr_ldvalue <= req_ldvalue[int'(pick_idx)*WIDTH +: WIDTH];
            remaining   <= req_len[int'(pick_idx)*LEN_W +: LEN_W];
            gnt         <= pick_onehot;
            ctr_ld      <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= (remaining == '0) ? ST_DONE : ST_COUNT;
        end
        ST_COUNT: begin
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1) || abort_now) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          result     <= ctr_dout;
          done_id    <= id;
          done       <= 1'b1;
          last_grant <= id;
          gnt        <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// Directed bench for counter_rr_scheduler with a behavioural loadable counter
// attached to the counter-control ports.
module tb_counter_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_ldvalue;
  logic [15:0] req_len;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  result;
  logic        aborted;
  logic        ctr_ld;
  logic [3:0]  ctr_ldvalue;
  logic [3:0]  ctr_q;

  int checks   = 0;
  int failures = 0;

  counter_rr_scheduler #(
    .NUM_REQ (4),
    .WIDTH   (4),
    .LEN_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_ldvalue (req_ldvalue),
    .req_len     (req_len),
    .gnt         (gnt),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .result      (result),
    .aborted     (aborted),
    .ctr_ld      (ctr_ld),
    .ctr_ldvalue (ctr_ldvalue),
    .ctr_dout    (ctr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter: synchronous load, otherwise +1 per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ctr_q <= 4'd0;
    else if (ctr_ld) ctr_q <= ctr_ldvalue;
    else             ctr_q <= ctr_q + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_done_id"}, 32'(done_id), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_aborted"}, 32'(aborted), 0);
    check({tag, "_ctr_ld"}, 32'(ctr_ld), 0);
    check({tag, "_ctr_ldvalue"}, 32'(ctr_ldvalue), 0);
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < maxc);
  endtask

  // Single request held until its done pulse; inputs are scrambled after latching.
  task automatic run_op(input int idx, input logic [3:0] ldv, input logic [3:0] len,
                        input string tag);
    int          n;
    bit          seen;
    logic [3:0]  exp_res;
    logic [3:0]  exp_gnt;
    exp_res = ldv + len;
    exp_gnt = 4'b0001 << idx;
    req_ldvalue[idx*4 +: 4] = ldv;
    req_len[idx*4 +: 4]     = len;
    req  = exp_gnt;
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (n == 1) begin
        check({tag, "_ctr_ld"}, 32'(ctr_ld), 1);
        check({tag, "_ctr_ldvalue"}, 32'(ctr_ldvalue), 32'(ldv));
        req_ldvalue = ~req_ldvalue;
        req_len     = ~req_len;
      end else if (n == 2) begin
        check({tag, "_ctr_ld_off"}, 32'(ctr_ld), 0);
      end
      if (done) seen = 1;
      else check({tag, "_gnt_held"}, 32'(gnt), 32'(exp_gnt));
    end
    req = 4'b0000;
    check({tag, "_latency"}, 32'(n), 32'(len) + 3);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_done_id"}, 32'(done_id), 32'(idx));
    check({tag, "_aborted"}, 32'(aborted), 0);
    check({tag, "_gnt_rel"}, 32'(gnt), 0);
    check({tag, "_busy_rel"}, 32'(busy), 0);
    step();
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_result_hold"}, 32'(result), 32'(exp_res));
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    int k;
    logic [1:0] exp_order [5];
    logic [3:0] exp_res4  [5];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_res4  = '{4'd4, 4'd7, 4'd10, 4'd13, 4'd4};

    rst_n       = 1'b0;
    req         = 4'b0000;
    req_ldvalue = 16'h0000;
    req_len     = 16'h0000;
    #3;
    check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_idle", 32'(busy), 0);

    run_op(0, 4'd5, 4'd3, "basic");
    run_op(0, 4'd14, 4'd3, "wrap");
    run_op(0, 4'd9, 4'd0, "len0");

    // Fresh reset so the rotation starts from requester 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_ldvalue = {4'd12, 4'd9, 4'd6, 4'd3};
    req_len     = {4'd1, 4'd1, 4'd1, 4'd1};
    req         = 4'b1111;
    k = 0;
    n = 0;
    while (k < 5 && n < 60) begin
      step();
      n++;
      check("rr_onehot", 32'($onehot0(gnt)), 1);
      if (done) begin
        check("rr_done_id", 32'(done_id), 32'(exp_order[k]));
        check("rr_result", 32'(result), 32'(exp_res4[k]));
        check("rr_spacing", 32'(n), 32'(4 * (k + 1)));
        k++;
        if (k == 5) req = 4'b0000;
      end
    end
    check("rr_all_done", 32'(k), 5);
    step();
    check("rr_idle_after", 32'(busy), 0);

    // Reset asserted mid-COUNT of requester 2.
    req_ldvalue[8 +: 4] = 4'd1;
    req_len[8 +: 4]     = 4'd10;
    req = 4'b0100;
    step();
    check("rst_mid_gnt", 32'(gnt), 32'b0100);
    step();
    step();
    check("rst_mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    check("rst_no_done", 32'(done), 0);
    req_ldvalue[0 +: 4] = 4'd7;
    req_len[0 +: 4]     = 4'd2;
    req   = 4'b0101;
    rst_n = 1'b1;
    step();
    check("rst_first_gnt", 32'(gnt), 32'b0001);
    check("rst_first_ldv", 32'(ctr_ldvalue), 7);
    req = 4'b0001;
    wait_done(20, n);
    req = 4'b0000;
    check("rst_op_done", 32'(done), 1);
    check("rst_op_latency", 32'(n), 4);
    check("rst_op_result", 32'(result), 9);
    check("rst_op_id", 32'(done_id), 0);
    step();
    check("rst_op_idle", 32'(busy), 0);

`ifdef CTR_SCHED_ABORT_EN
    req_ldvalue[4 +: 4] = 4'd3;
    req_len[4 +: 4]     = 4'd10;
    req = 4'b0010;
    step();
    step();
    step();
    req = 4'b0000;
    wait_done(20, n);
    check("abort_done", 32'(done), 1);
    check("abort_latency", 32'(n), 2);
    check("abort_result", 32'(result), 5);
    check("abort_flag", 32'(aborted), 1);
    check("abort_id", 32'(done_id), 1);
    step();
    run_op(0, 4'd2, 4'd1, "abort_clear");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
